// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
//
// Receive-side monitor for a VGA timing stream sampled in the sys_clk domain.
// Detects hSync/vSync falling edges, checks the line period and the frame
// length, locks onto the stream, regenerates pixel/line counters and counts
// timing errors seen while locked.
//
// Optional feature: define PIXEL_CRC_EN to build the per-frame pixel checksum
// on frameSum. Without it frameSum is tied to 0 and bright/rgb are unused.
//
// Ports:
//   clk        system clock (sys_clk)
//   reset      asynchronous, active-high reset
//   hSync      horizontal sync, active-low
//   vSync      vertical sync, active-low
//   bright     active-video flag
//   rgb        pixel colour {R,G,B}, 4 bits each
//   locked     high while the receiver is LOCKED
//   hCountRx   regenerated pixel index
//   vCountRx   regenerated line index
//   frameDone  one-cycle pulse on each good frame end while LOCKED
//   lineErr    one-cycle pulse on a timing error in LOCKING or LOCKED
//   errCount   saturating count of errors seen in LOCKED
//   frameSum   per-frame pixel checksum (PIXEL_CRC_EN only)
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int CLK_PER_PIX = 4,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hSync,
   input  logic        vSync,
   input  logic        bright,
   input  logic [11:0] rgb,
   output logic        locked,
   output logic [9:0]  hCountRx,
   output logic [9:0]  vCountRx,
   output logic        frameDone,
   output logic        lineErr,
   output logic [7:0]  errCount,
   output logic [15:0] frameSum
);

   localparam int LINE_CLKS = H_TOTAL * CLK_PER_PIX;
   localparam int PD_W      = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

   typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

   state_t            r_state;
   logic              r_hs_d, r_vs_d;
   logic [11:0]       r_clk_cnt;
   logic              r_have_prev;
   logic [9:0]        r_line_cnt;
   logic [PD_W-1:0]   r_pix_div;
   logic [9:0]        r_h_count, r_v_count;
   logic [7:0]        r_lock_cnt;
   logic              r_frame_bad;
   logic              r_locked, r_line_err, r_frame_done;
   logic [7:0]        r_err_count;

   logic              w_h_edge, w_v_edge;
   logic              w_line_bad, w_len_bad;
   logic [10:0]       w_frame_lines;

   assign w_h_edge = r_hs_d & ~hSync;
   assign w_v_edge = r_vs_d & ~vSync;

   // The line just ended is one clock longer than clkCnt shows, because the
   // counter is cleared on the edge cycle itself.
   assign w_line_bad = w_h_edge && r_have_prev &&
                       (({1'b0, r_clk_cnt} + 13'd1) != 13'(LINE_CLKS));

   // A coincident hSync edge belongs to the frame that is ending.
   assign w_frame_lines = {1'b0, r_line_cnt} + {10'd0, w_h_edge};
   assign w_len_bad     = (w_frame_lines != 11'(V_TOTAL));

   // Edge registers and the free-running timing counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hs_d     <= 1'b0;
         r_vs_d     <= 1'b0;
         r_clk_cnt  <= '0;
         r_line_cnt <= '0;
         r_pix_div  <= '0;
         r_h_count  <= '0;
         r_v_count  <= '0;
      end else begin
         r_hs_d <= hSync;
         r_vs_d <= vSync;

         if (w_h_edge)
            r_clk_cnt <= '0;
         else if (r_clk_cnt != 12'hFFF)
            r_clk_cnt <= r_clk_cnt + 12'd1;

         if (w_v_edge)
            r_line_cnt <= '0;
         else if (w_h_edge && (r_line_cnt != 10'h3FF))
            r_line_cnt <= r_line_cnt + 10'd1;

         if (w_h_edge) begin
            r_pix_div <= '0;
            r_h_count <= '0;
         end else if (r_pix_div == PD_W'(CLK_PER_PIX - 1)) begin
            r_pix_div <= '0;
            r_h_count <= (r_h_count == 10'(H_TOTAL - 1)) ? 10'd0 : r_h_count + 10'd1;
         end else begin
            r_pix_div <= r_pix_div + 1'b1;
         end

         // vSync edge wins over a coincident line increment.
         if (w_v_edge)
            r_v_count <= '0;
         else if (w_h_edge)
            r_v_count <= (r_v_count == 10'(V_TOTAL - 1)) ? 10'd0 : r_v_count + 10'd1;
      end
   end

   // Lock state machine with registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= SEARCH;
         r_lock_cnt   <= '0;
         r_have_prev  <= 1'b0;
         r_frame_bad  <= 1'b0;
         r_locked     <= 1'b0;
         r_line_err   <= 1'b0;
         r_frame_done <= 1'b0;
         r_err_count  <= '0;
      end else begin
         r_line_err   <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_h_edge)
            r_have_prev <= 1'b1;
         if (w_v_edge)
            r_frame_bad <= 1'b0;
         else if ((r_state == LOCKING) && w_line_bad)
            r_frame_bad <= 1'b1;

         case (r_state)
            SEARCH: begin
               r_locked <= 1'b0;
               if (w_v_edge) begin
                  r_state    <= LOCKING;
                  r_lock_cnt <= '0;
               end
            end
            LOCKING: begin
               r_locked <= 1'b0;
               if (w_line_bad || (w_v_edge && w_len_bad))
                  r_line_err <= 1'b1;
               if (w_v_edge) begin
                  if (w_line_bad || w_len_bad || r_frame_bad) begin
                     r_state     <= SEARCH;
                     r_have_prev <= 1'b0;
                  end else if ((r_lock_cnt + 8'd1) == 8'(LOCK_FRAMES)) begin
                     r_state  <= LOCKED;
                     r_locked <= 1'b1;
                  end else begin
                     r_lock_cnt <= r_lock_cnt + 8'd1;
                  end
               end
            end
            LOCKED: begin
               if (w_line_bad || (w_v_edge && w_len_bad)) begin
                  r_line_err  <= 1'b1;
                  r_state     <= SEARCH;
                  r_have_prev <= 1'b0;
                  r_locked    <= 1'b0;
                  if (r_err_count != 8'hFF)
                     r_err_count <= r_err_count + 8'd1;
               end else begin
                  r_locked <= 1'b1;
                  if (w_v_edge)
                     r_frame_done <= 1'b1;
               end
            end
            default: begin
               r_state  <= SEARCH;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIXEL_CRC_EN
   logic [15:0] r_frame_acc, r_frame_sum;
   logic [15:0] w_pix_add;

   // One sample per pixel: take rgb on the first sys_clk of each pixel.
   assign w_pix_add = (bright && (r_pix_div == '0)) ? {4'd0, rgb} : 16'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_acc <= '0;
         r_frame_sum <= '0;
      end else if (w_v_edge) begin
         r_frame_sum <= r_frame_acc + w_pix_add;
         r_frame_acc <= '0;
      end else begin
         r_frame_acc <= r_frame_acc + w_pix_add;
      end
   end

   assign frameSum = r_frame_sum;
`else
   logic w_unused_pix;
   assign w_unused_pix = ^{bright, rgb};
   assign frameSum     = 16'd0;
`endif

   assign locked    = r_locked;
   assign hCountRx  = r_h_count;
   assign vCountRx  = r_v_count;
   assign frameDone = r_frame_done;
   assign lineErr   = r_line_err;
   assign errCount  = r_err_count;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_receiver
//
// Directed bench for vga_sync_receiver with a reduced timing set
// (10 pixels x 6 lines, 2 clocks per pixel, 2 lock frames). Lines are 20
// clocks with hSync low for the first 2 clocks; vSync falls inside line 0.
// -----------------------------------------------------------------------------
module tb_vga_sync_receiver;

   logic        clk = 1'b0;
   logic        reset;
   logic        hSync, vSync, bright;
   logic [11:0] rgb;
   logic        locked, frameDone, lineErr;
   logic [9:0]  hCountRx, vCountRx;
   logic [7:0]  errCount;
   logic [15:0] frameSum;

   int vectors     = 0;
   int miscompares = 0;

   int          n_vfall, n_lineerr, n_framedone;
   logic        lk_before [0:15];
   logic        lk_after  [0:15];
   logic        fd_at     [0:15];
   logic [9:0]  vc_at     [0:15];
   logic [15:0] fs_at     [0:15];
   logic        err_lk_before, err_lk_after;
   logic        prev_v;
   logic [15:0] exp_sum;

   always #5 clk = ~clk;

   vga_sync_receiver #(
      .H_TOTAL    (10),
      .V_TOTAL    (6),
      .CLK_PER_PIX(2),
      .LOCK_FRAMES(2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .hSync    (hSync),
      .vSync    (vSync),
      .bright   (bright),
      .rgb      (rgb),
      .locked   (locked),
      .hCountRx (hCountRx),
      .vCountRx (vCountRx),
      .frameDone(frameDone),
      .lineErr  (lineErr),
      .errCount (errCount),
      .frameSum (frameSum)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One sys_clk: drive syncs, clock, sample #1 after the edge and log events.
   task automatic cyc(input logic h, input logic v);
      logic lb;
      lb    = locked;
      hSync = h;
      vSync = v;
      @(posedge clk);
      #1;
      if (prev_v && !v && n_vfall < 15) begin
         n_vfall++;
         lk_before[n_vfall] = lb;
         lk_after[n_vfall]  = locked;
         fd_at[n_vfall]     = frameDone;
         vc_at[n_vfall]     = vCountRx;
         fs_at[n_vfall]     = frameSum;
      end
      if (lineErr) begin
         n_lineerr++;
         err_lk_before = lb;
         err_lk_after  = locked;
      end
      if (frameDone)
         n_framedone++;
      prev_v = v;
   endtask

   task automatic line(input int len, input logic vfall_en, input int vpos,
                       input logic chk_h, input logic brt);
      for (int c = 0; c < len; c++) begin
         bright = brt && (c >= 5) && (c <= 12);
         rgb    = bright ? 12'hFFF : 12'h000;
         cyc((c < 2) ? 1'b0 : 1'b1, (vfall_en && (c >= vpos)) ? 1'b0 : 1'b1);
         if (chk_h)
            check("hcount_seq", 32'(hCountRx), 32'(c / 2));
      end
   endtask

   task automatic frame(input int nl, input int vpos, input int bad_line,
                        input int chk_line, input int brt_line);
      for (int l = 0; l < nl; l++)
         line((l == bad_line) ? 19 : 20, l == 0, vpos, l == chk_line, l == brt_line);
   endtask

   task automatic clear_log();
      n_vfall     = 0;
      n_lineerr   = 0;
      n_framedone = 0;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      hSync  = 1'b1;
      vSync  = 1'b1;
      bright = 1'b0;
      rgb    = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      prev_v = 1'b1;
      clear_log();
      repeat (2) cyc(1'b1, 1'b1);
      line(20, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      reset  = 1'b1;
      hSync  = 1'b1;
      vSync  = 1'b1;
      bright = 1'b0;
      rgb    = 12'h000;
      prev_v = 1'b1;
      err_lk_before = 1'b0;
      err_lk_after  = 1'b0;
      clear_log();
`ifdef PIXEL_CRC_EN
      exp_sum = 16'h3FFC;
`else
      exp_sum = 16'h0000;
`endif

      // Reset state
      #12;
      check("rst_locked",    32'(locked),    32'd0);
      check("rst_hcount",    32'(hCountRx),  32'd0);
      check("rst_vcount",    32'(vCountRx),  32'd0);
      check("rst_framedone", 32'(frameDone), 32'd0);
      check("rst_lineerr",   32'(lineErr),   32'd0);
      check("rst_errcount",  32'(errCount),  32'd0);
      check("rst_framesum",  32'(frameSum),  32'd0);

      // Clean stream: lock on the 3rd vSync edge, frameDone from the 4th
      do_reset();
      for (int f = 1; f <= 5; f++)
         frame(6, 5, -1, (f == 5) ? 1 : -1, -1);
      check("clean_lock_e2",      32'(lk_after[2]),  32'd0);
      check("clean_lock_pre_e3",  32'(lk_before[3]), 32'd0);
      check("clean_lock_e3",      32'(lk_after[3]),  32'd1);
      check("clean_fd_e3",        32'(fd_at[3]),     32'd0);
      check("clean_fd_e4",        32'(fd_at[4]),     32'd1);
      check("clean_fd_count",     32'(n_framedone),  32'd2);
      check("clean_lineerr",      32'(n_lineerr),    32'd0);
      check("clean_errcount",     32'(errCount),     32'd0);
      check("clean_vcount_end",   32'(vCountRx),     32'd5);
      check("clean_locked",       32'(locked),       32'd1);

      // Locked stream with one 19-clock line, then relock
      clear_log();
      frame(6, 5, 2, -1, -1);
      check("short_lineerr",      32'(n_lineerr),     32'd1);
      check("short_errcount",     32'(errCount),      32'd1);
      check("short_lock_before",  32'(err_lk_before), 32'd1);
      check("short_lock_after",   32'(err_lk_after),  32'd0);
      for (int f = 0; f < 3; f++)
         frame(6, 5, -1, -1, -1);
      check("relock_e3",          32'(lk_after[3]),   32'd0);
      check("relock_e4",          32'(lk_after[4]),   32'd1);
      check("relock_fd_count",    32'(n_framedone),   32'd1);
      check("relock_lineerr",     32'(n_lineerr),     32'd1);
      check("relock_errcount",    32'(errCount),      32'd1);

      // Reset mid-frame while locked: outputs clear without waiting for clk
      line(20, 1'b1, 5, 1'b0, 1'b0);
      for (int c = 0; c < 7; c++)
         cyc((c < 2) ? 1'b0 : 1'b1, 1'b1);
      check("pre_rst_locked",   32'(locked),   32'd1);
      check("pre_rst_errcount", 32'(errCount), 32'd1);
      check("pre_rst_hcount",   32'(hCountRx), 32'd3);
      #2;
      reset = 1'b1;
      #1;
      check("arst_locked",    32'(locked),    32'd0);
      check("arst_errcount",  32'(errCount),  32'd0);
      check("arst_hcount",    32'(hCountRx),  32'd0);
      check("arst_vcount",    32'(vCountRx),  32'd0);
      check("arst_lineerr",   32'(lineErr),   32'd0);
      check("arst_framedone", 32'(frameDone), 32'd0);
      do_reset();
      for (int f = 0; f < 3; f++)
         frame(6, 5, -1, -1, -1);
      check("arst_relock_e2", 32'(lk_after[2]), 32'd0);
      check("arst_relock_e3", 32'(lk_after[3]), 32'd1);

      // Five-line frame during LOCKING
      do_reset();
      frame(6, 5, -1, -1, -1);
      frame(5, 5, -1, -1, -1);
      frame(6, 5, -1, -1, -1);
      check("short_frame_lineerr",  32'(n_lineerr),   32'd1);
      check("short_frame_errcount", 32'(errCount),    32'd0);
      check("short_frame_locked",   32'(locked),      32'd0);
      check("short_frame_e3_lock",  32'(lk_after[3]), 32'd0);
      for (int f = 0; f < 3; f++)
         frame(6, 5, -1, -1, -1);
      check("short_frame_e5_lock",  32'(lk_after[5]), 32'd0);
      check("short_frame_e6_lock",  32'(lk_after[6]), 32'd1);
      check("short_frame_err_end",  32'(n_lineerr),   32'd1);
      check("short_frame_cnt_end",  32'(errCount),    32'd0);

      // Coincident hSync/vSync edges, plus a bright window for the checksum
      do_reset();
      frame(6, 0, -1, -1, -1);
      frame(6, 0, -1, -1, -1);
      frame(6, 0, -1, -1, 2);
      frame(6, 0, -1, -1, -1);
      check("coin_vcount_e1",  32'(vc_at[1]),    32'd0);
      check("coin_vcount_e3",  32'(vc_at[3]),    32'd0);
      check("coin_lock_e2",    32'(lk_after[2]), 32'd0);
      check("coin_lock_e3",    32'(lk_after[3]), 32'd1);
      check("coin_lineerr",    32'(n_lineerr),   32'd0);
      check("coin_fd_e4",      32'(fd_at[4]),    32'd1);
      check("sum_e3",          32'(fs_at[3]),    32'd0);
      check("sum_e4",          32'(fs_at[4]),    32'(exp_sum));
      check("sum_hold",        32'(frameSum),    32'(exp_sum));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the display controller's VGA timing output; consumes hSync, vSync, bright and the 12-bit rgb bus in the sys_clk domain.
- Checks line and frame timing against the 640x480 parameters and locks onto the stream.
- Regenerates pixel and line counters and counts timing errors.
- Used as an on-chip and bench monitor for the video path; status goes to LEDs and SSDs.

Parameters:
- H_TOTAL, 800, pixels per line including blanking
- V_TOTAL, 525, lines per frame including blanking
- CLK_PER_PIX, 4, sys_clk cycles per pixel
- LOCK_FRAMES, 2, consecutive good frames required to reach LOCKED

Ports:
- clk  in  1  system clock (sys_clk)
- reset  in  1  asynchronous, active-high reset
- hSync  in  1  horizontal sync, active-low
- vSync  in  1  vertical sync, active-low
- bright  in  1  active-video flag
- rgb  in  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- locked  out  1  high while in LOCKED
- hCountRx  out  10  regenerated pixel index; 0 on the cycle of the hSync falling edge
- vCountRx  out  10  regenerated line index; 0 on the cycle of the vSync falling edge
- frameDone  out  1  one-cycle pulse on each good frame end while LOCKED
- lineErr  out  1  one-cycle pulse on a timing error in LOCKING or LOCKED
- errCount  out  8  saturating count of errors seen in LOCKED
- frameSum  out  16  per-frame pixel checksum (optional feature)

Behaviour:
- Clocking and reset: one clock `clk`; asynchronous, active-high `reset`. All outputs are 0 in reset. State resets to SEARCH.
- Edge detection: hSync and vSync are registered once. A falling edge is registered value 1 and current value 0. Edge outputs update one cycle after the edge.
- clkCnt (12b, saturates at 4095): counts cycles since the last hSync falling edge and is cleared on each edge.
- Line period check: good when clkCnt+1 == H_TOTAL*CLK_PER_PIX. The check is skipped until the first hSync edge after reset or after entering SEARCH (flag havePrev).
- lineCnt (10b, saturates): counts hSync edges since the last vSync edge.
- Frame length check: at a vSync edge the frame is good when lineCnt == V_TOTAL. A coincident hSync edge is counted into the ending frame before the check, then lineCnt clears to 0.
- hCountRx / vCountRx:
  - pixDiv counts 0..CLK_PER_PIX-1; hCountRx increments when pixDiv wraps, wraps at H_TOTAL-1, and clears with pixDiv on an hSync edge.
  - vCountRx increments on each hSync edge, wraps at V_TOTAL-1, and clears on a vSync edge. A vSync edge overrides a coincident increment.
- FSM:
  - SEARCH: a vSync edge moves to LOCKING with lockCnt=0.
  - LOCKING: a bad line period marks the frame bad and pulses lineErr. At a vSync edge, a good frame increments lockCnt; reaching LOCK_FRAMES moves to LOCKED. A bad frame moves to SEARCH.
  - LOCKED: a bad line period or bad frame pulses lineErr, increments errCount (saturates at 255, never wraps) and moves to SEARCH. A good vSync edge pulses frameDone.
- locked is registered from state, so it drops the cycle after leaving LOCKED.
- A reset mid-frame clears everything, including errCount and havePrev.

Optional Feature:
- Macro PIXEL_CRC_EN.
- When defined:
  - frameAcc (16b) adds the zero-extended rgb, mod 2^16, on each cycle with bright=1 and pixDiv==0.
  - At each vSync edge, frameSum <= frameAcc plus any coincident add, and frameAcc clears.
  - frameSum updates in every state.
- When undefined: frameSum is held 0 and bright/rgb are ignored (no logic).

Test Plan:
- Bench overrides H_TOTAL=10, V_TOTAL=6, CLK_PER_PIX=2, LOCK_FRAMES=2 for every scenario.
- Clean stream, line period 20 clocks: locked rises 1 cycle after the 3rd vSync falling edge. frameDone pulses on the 4th edge. errCount stays 0. hCountRx sequence is 0,0,1,1,..,9,9.
- Locked stream with one line of 19 clocks: lineErr pulses once, errCount=1, locked drops the next cycle, and relock follows after 2 good frames.
- Frame of 5 lines during LOCKING: back to SEARCH, lineErr pulse, errCount stays 0, locked stays 0.
- hSync and vSync falling on the same cycle: the frame counts 6 lines and passes; vCountRx=0 the next cycle.
- Reset asserted mid-frame while LOCKED: all outputs are 0 immediately (asynchronous), and lock requires SEARCH plus 2 full frames again.
- With PIXEL_CRC_EN defined, bright=1 for 4 pixels with rgb=12'hFFF in one frame: frameSum=16'h3FFC after the next vSync edge. Without the macro, frameSum=0.
